// File: rtl/div_iter.sv
// Iterative restoring integer divider (signed/unsigned), one quotient bit per clock.
// Latency: WIDTH cycles from accept edge to out_valid; 1 cycle for divide-by-zero (and early exit).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, no same-cycle re-accept.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        operand handshake (dividend, divisor, is_signed sampled on it)
//   out_valid / out_ready      result handshake (quotient, remainder, div_by_zero held until taken)
//
// Optional build macro: DIV_EARLY_EXIT_EN -- finish in one cycle when |divisor| > |dividend|.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd_sh;     // dividend magnitude, MSB feeds the next iteration
    logic [WIDTH-1:0] dsr_mag;    // divisor magnitude
    logic [WIDTH-1:0] q_sh;       // quotient bits collected so far
    logic [WIDTH:0]   prem;       // partial remainder, extra bit holds the borrow
    logic             q_neg;
    logic             r_neg;

    // operand decode in IDLE
    logic             dvd_neg_in;
    logic             dsr_neg_in;
    logic [WIDTH-1:0] dvd_mag_in;
    logic [WIDTH-1:0] dsr_mag_in;
    logic             divisor_zero;
    logic             early_exit;
    logic             accept;

    // one restoring step
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             q_bit;
    logic [WIDTH:0]   rem_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             last;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;

    assign dvd_neg_in   = is_signed & dividend[WIDTH-1];
    assign dsr_neg_in   = is_signed & divisor[WIDTH-1];
    // The most negative value maps onto itself, which read unsigned is its true magnitude.
    assign dvd_mag_in   = dvd_neg_in ? (~dividend + WIDTH'(1)) : dividend;
    assign dsr_mag_in   = dsr_neg_in ? (~divisor  + WIDTH'(1)) : divisor;
    assign divisor_zero = (divisor == '0);

`ifdef DIV_EARLY_EXIT_EN
    assign early_exit = (dsr_mag_in > dvd_mag_in);
`else
    assign early_exit = 1'b0;
`endif

    // The restored remainder is always below the divisor, so the shifted value is below
    // twice the divisor and a WIDTH+1 bit subtraction flags the borrow in its top bit.
    assign rem_sh  = (prem << 1) | {{WIDTH{1'b0}}, dvd_sh[WIDTH-1]};
    assign diff    = rem_sh - {1'b0, dsr_mag};
    assign q_bit   = ~diff[WIDTH];
    assign rem_nxt = q_bit ? diff : rem_sh;
    assign q_nxt   = {q_sh[WIDTH-2:0], q_bit};
    assign last    = (cnt == CW'(WIDTH - 1));
    assign q_fin   = q_neg ? (~q_nxt + WIDTH'(1)) : q_nxt;
    assign r_fin   = r_neg ? (~rem_nxt[WIDTH-1:0] + WIDTH'(1)) : rem_nxt[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (divisor_zero || early_exit) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            dvd_sh      <= '0;
            dsr_mag     <= '0;
            q_sh        <= '0;
            prem        <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (divisor_zero) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else if (early_exit) begin
                            quotient    <= '0;
                            remainder   <= dividend;
                            div_by_zero <= 1'b0;
                        end else begin
                            dvd_sh      <= dvd_mag_in;
                            dsr_mag     <= dsr_mag_in;
                            q_neg       <= dvd_neg_in ^ dsr_neg_in;
                            r_neg       <= dvd_neg_in;
                            prem        <= '0;
                            q_sh        <= '0;
                            cnt         <= '0;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    prem   <= rem_nxt;
                    q_sh   <= q_nxt;
                    dvd_sh <= dvd_sh << 1;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        quotient  <= q_fin;
                        remainder <= r_fin;
                        cnt       <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
